gps_pps_qualifier: RTL and testbench
====================================

Name: gps_pps_qualifier

Overview:
Conditions the raw GPS 1PPS input before it reaches the PLL reference gate counter. It synchronises and deglitches the pin, then measures the interval between accepted rising edges in system clock cycles. Only edges whose interval lies within a tolerance window are forwarded as single-cycle qualified pulses. It also reports lock, missing-pulse and out-of-range status for the SPI status word and FPGA_INT.

Parameters:
SYNC_STAGES, 2, flip-flops in the pps_in synchroniser (minimum 2)
MIN_HIGH_CYCLES, 4, consecutive synchronised-high cycles needed to accept an edge (minimum 1)
CNT_WIDTH, 32, width of the interval counter and the interval output
NOMINAL_CYCLES, 5000000, expected clk cycles per PPS period
TOL_CYCLES, 5000, allowed absolute deviation from NOMINAL_CYCLES
LOCK_COUNT, 4, consecutive good intervals required to assert locked

Ports:
clk  in  1  system clock (system_clk[0] domain)
rst  in  1  asynchronous, active-high reset
pps_in  in  1  raw GPS_PULSE pin, asynchronous
clear_flags  in  1  one-cycle strobe that clears the sticky flags
pps_edge  out  1  one-cycle strobe on every accepted edge, qualified or not
pps_out  out  1  one-cycle strobe on each qualified (in-window) edge
interval  out  CNT_WIDTH  last measured interval, valid from interval_stb onward
interval_stb  out  1  one-cycle strobe when interval updates
locked  out  1  asserted after LOCK_COUNT consecutive good intervals
err_missing  out  1  sticky: timeout with no edge
err_range  out  1  sticky: measured interval outside the window

Behaviour:
- Reset (async): all outputs 0, interval 0, synchroniser and filter cleared, good_run 0, FSM in SEARCH.
- Front end:
  - pps_in passes through SYNC_STAGES flops, then a high-run counter.
  - An edge is accepted in the cycle the run first reaches MIN_HIGH_CYCLES. The run must then drop low before another edge can be accepted.
  - Latency from the synchronised rising edge to the accept cycle is fixed: MIN_HIGH_CYCLES-1 cycles after the first synchronised-high cycle.
  - Highs shorter than MIN_HIGH_CYCLES are ignored entirely.
- pps_edge pulses in the accept cycle.
- FSM state SEARCH:
  - Counter idle.
  - On an accepted edge: counter cleared to 0, state goes to TRACK. No interval_stb and no pps_out.
- FSM state TRACK:
  - Counter increments by 1 every cycle.
  - On an accepted edge: interval <= counter+1, which equals the cycle distance between the two accept cycles. interval_stb pulses one cycle later, aligned with interval, and the counter is cleared to 0.
  - Good edge (NOMINAL-TOL <= interval <= NOMINAL+TOL, evaluated on counter+1):
    - pps_out pulses in the same cycle as interval_stb.
    - good_run increments, saturating at LOCK_COUNT.
    - locked is set in the cycle good_run reaches LOCK_COUNT.
  - Bad edge (early or late):
    - No pps_out.
    - good_run <= 0, locked <= 0, err_range <= 1.
    - Remains in TRACK; this edge becomes the new reference.
  - Timeout: when the counter reaches NOMINAL+TOL with no edge in that cycle:
    - err_missing <= 1, locked <= 0, good_run <= 0.
    - State goes to SEARCH.
    - An edge in that same cycle is evaluated as a good edge; no timeout is raised.
- Sticky flags:
  - clear_flags clears err_missing and err_range.
  - If a set event occurs in the same cycle as clear_flags, the set wins.
- Compile-time checks: NOMINAL_CYCLES+TOL_CYCLES < 2**CNT_WIDTH and TOL_CYCLES < NOMINAL_CYCLES; violation is a fatal elaboration error. Under these checks the counter never wraps.
- Reset mid-interval: everything returns to SEARCH; the next edge only establishes a reference.

Decomposition:
- Package gps_pps_pkg:
  - FSM state encoding (SEARCH=1'b0, TRACK=1'b1).
  - Window-bound localparams (LO = NOMINAL-TOL, HI = NOMINAL+TOL), provided as functions of the parameters.
- Sub-module pps_edge_filter (SYNC_STAGES, MIN_HIGH_CYCLES):
  - Ports clk, rst, in, edge_stb.
  - Contains the synchroniser and the high-run filter.
- Top-level holds the counter, the FSM, window compare, lock and flags.

Test Plan:
(All scenarios use NOMINAL=100, TOL=2, MIN_HIGH=3, SYNC=2, LOCK_COUNT=3.)
- Five clean 10-cycle-high pulses spaced 100 cycles -> first gives pps_edge only. Each later one gives interval=100, interval_stb, pps_out. locked rises at the 4th pulse. No error flags.
- 2-cycle-high glitch at cycle 50 of a locked period -> no pps_edge. Next pulse at 100 still qualifies; locked stays 1.
- While locked, pulse arrives after 97 cycles -> interval=97, no pps_out, err_range=1, locked=0. Following pulses at +100 relock after 3 good intervals.
- Pulse stream stops -> at counter=102 err_missing=1, locked=0, SEARCH. The next pulse gives pps_edge only, no interval_stb.
- Edge in exactly the cycle counter=101 (interval 102) -> good edge, pps_out=1, no err_missing. clear_flags in the same cycle as an err_range event -> err_range remains 1.
- Assert rst at cycle 40 of a TRACK period -> all outputs 0 immediately (async). The first post-reset pulse yields no interval_stb.

Source files
------------

// File: rtl/gps_pps_pkg.sv
// Shared types and helpers for the GPS 1PPS qualifier.
// Holds the FSM state encoding and the acceptance-window bounds.
package gps_pps_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    TRACK  = 1'b1
  } state_t;

  function automatic longint unsigned win_lo(input longint unsigned nominal,
                                             input longint unsigned tol);
    return nominal - tol;
  endfunction

  function automatic longint unsigned win_hi(input longint unsigned nominal,
                                             input longint unsigned tol);
    return nominal + tol;
  endfunction

endpackage

// File: rtl/pps_edge_filter.sv
// Synchronises the raw PPS pin and accepts a rising edge only once it has
// stayed high for MIN_HIGH_CYCLES consecutive synchronised cycles.
module pps_edge_filter #(
  parameter int SYNC_STAGES     = 2,
  parameter int MIN_HIGH_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic edge_stb
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $fatal(1, "pps_edge_filter: SYNC_STAGES must be at least 2");
  end
  if (MIN_HIGH_CYCLES < 1) begin : g_bad_high
    $fatal(1, "pps_edge_filter: MIN_HIGH_CYCLES must be at least 1");
  end

  localparam int RW = $clog2(MIN_HIGH_CYCLES + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(MIN_HIGH_CYCLES);
  localparam logic [RW-1:0] RUN_HIT = RW'(MIN_HIGH_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [RW-1:0]          run_reg;
  logic                   synced;

  assign synced = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], in};
    end
  end

  // Run saturates at MIN_HIGH_CYCLES so a long high accepts exactly once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_reg <= '0;
    end else if (!synced) begin
      run_reg <= '0;
    end else if (run_reg != RUN_MAX) begin
      run_reg <= run_reg + RW'(1);
    end
  end

  assign edge_stb = synced && (run_reg == RUN_HIT);

endmodule

// File: rtl/gps_pps_qualifier.sv
// GPS 1PPS qualifier: measures the interval between accepted edges, forwards
// in-window edges as pps_out and reports lock / missing / range status.
module gps_pps_qualifier
  import gps_pps_pkg::*;
#(
  parameter int          SYNC_STAGES     = 2,
  parameter int          MIN_HIGH_CYCLES = 4,
  parameter int          CNT_WIDTH       = 32,
  parameter int unsigned NOMINAL_CYCLES  = 5000000,
  parameter int unsigned TOL_CYCLES      = 5000,
  parameter int          LOCK_COUNT      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pps_in,
  input  logic                 clear_flags,
  output logic                 pps_edge,
  output logic                 pps_out,
  output logic [CNT_WIDTH-1:0] interval,
  output logic                 interval_stb,
  output logic                 locked,
  output logic                 err_missing,
  output logic                 err_range
);

  if ((64'(NOMINAL_CYCLES) + 64'(TOL_CYCLES)) >= (64'd1 << CNT_WIDTH)) begin : g_bad_width
    $fatal(1, "gps_pps_qualifier: NOMINAL_CYCLES+TOL_CYCLES does not fit CNT_WIDTH");
  end
  if (TOL_CYCLES >= NOMINAL_CYCLES) begin : g_bad_tol
    $fatal(1, "gps_pps_qualifier: TOL_CYCLES must be below NOMINAL_CYCLES");
  end

  localparam logic [CNT_WIDTH-1:0] LO = CNT_WIDTH'(win_lo(64'(NOMINAL_CYCLES), 64'(TOL_CYCLES)));
  localparam logic [CNT_WIDTH-1:0] HI = CNT_WIDTH'(win_hi(64'(NOMINAL_CYCLES), 64'(TOL_CYCLES)));
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0] GR_MAX = GW'(LOCK_COUNT);

  state_t               state_reg, state_next;
  logic                 acc_edge;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next, cnt_plus1;
  logic [CNT_WIDTH-1:0] interval_reg, interval_next;
  logic [GW-1:0]        good_run_reg, good_run_next;
  logic                 locked_reg, locked_next;
  logic                 err_range_reg, err_range_next;
  logic                 err_missing_reg, err_missing_next;
  logic                 stb_reg, stb_next;
  logic                 pps_reg, pps_next;
  logic                 in_window, good_edge, bad_edge, timeout;

  pps_edge_filter #(
    .SYNC_STAGES     (SYNC_STAGES),
    .MIN_HIGH_CYCLES (MIN_HIGH_CYCLES)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .in       (pps_in),
    .edge_stb (acc_edge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= SEARCH;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SEARCH:  if (acc_edge) state_next = TRACK;
      TRACK:   if (timeout) state_next = SEARCH;
      default: state_next = SEARCH;
    endcase
  end

  // Window compare uses counter+1, the distance between the two accept cycles.
  always_comb begin
    cnt_plus1        = cnt_reg + CNT_WIDTH'(1);
    in_window        = (cnt_plus1 >= LO) && (cnt_plus1 <= HI);
    good_edge        = (state_reg == TRACK) && acc_edge && in_window;
    bad_edge         = (state_reg == TRACK) && acc_edge && !in_window;
    timeout          = (state_reg == TRACK) && !acc_edge && (cnt_plus1 == HI);
    cnt_next         = cnt_reg;
    interval_next    = interval_reg;
    good_run_next    = good_run_reg;
    locked_next      = locked_reg;
    stb_next         = (state_reg == TRACK) && acc_edge;
    pps_next         = good_edge;
    if (acc_edge)                cnt_next = '0;
    else if (state_reg == TRACK) cnt_next = cnt_plus1;
    if (stb_next) interval_next = cnt_plus1;
    if (good_edge) begin
      if (good_run_reg != GR_MAX) good_run_next = good_run_reg + GW'(1);
      locked_next = locked_reg || (good_run_next == GR_MAX);
    end else if (bad_edge || timeout) begin
      good_run_next = '0;
      locked_next   = 1'b0;
    end
    err_range_next   = bad_edge || (err_range_reg && !clear_flags);
    err_missing_next = timeout || (err_missing_reg && !clear_flags);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg         <= '0;
      interval_reg    <= '0;
      good_run_reg    <= '0;
      locked_reg      <= 1'b0;
      err_range_reg   <= 1'b0;
      err_missing_reg <= 1'b0;
      stb_reg         <= 1'b0;
      pps_reg         <= 1'b0;
    end else begin
      cnt_reg         <= cnt_next;
      interval_reg    <= interval_next;
      good_run_reg    <= good_run_next;
      locked_reg      <= locked_next;
      err_range_reg   <= err_range_next;
      err_missing_reg <= err_missing_next;
      stb_reg         <= stb_next;
      pps_reg         <= pps_next;
    end
  end

  assign pps_edge     = acc_edge;
  assign pps_out      = pps_reg;
  assign interval     = interval_reg;
  assign interval_stb = stb_reg;
  assign locked       = locked_reg;
  assign err_missing  = err_missing_reg;
  assign err_range    = err_range_reg;

endmodule

// File: tb/tb_gps_pps_qualifier.sv
// Directed bench for gps_pps_qualifier: expected edges and interval strobes are
// queued when a pulse is driven and matched when the DUT produces them.
module tb_gps_pps_qualifier;

  logic        clk;
  logic        rst;
  logic        pps_in;
  logic        clear_flags;
  logic        pps_edge;
  logic        pps_out;
  logic [31:0] interval;
  logic        interval_stb;
  logic        locked;
  logic        err_missing;
  logic        err_range;

  typedef struct {
    int          at;
    logic [31:0] iv;
    logic        pps;
    logic        lck;
    logic        er;
    logic        em;
  } exp_t;

  exp_t exp_q[$];
  int   edge_q[$];
  int   cyc;
  int   n_assert;
  int   n_fail;

  gps_pps_qualifier #(
    .SYNC_STAGES     (2),
    .MIN_HIGH_CYCLES (3),
    .CNT_WIDTH       (32),
    .NOMINAL_CYCLES  (100),
    .TOL_CYCLES      (2),
    .LOCK_COUNT      (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pps_in       (pps_in),
    .clear_flags  (clear_flags),
    .pps_edge     (pps_edge),
    .pps_out      (pps_out),
    .interval     (interval),
    .interval_stb (interval_stb),
    .locked       (locked),
    .err_missing  (err_missing),
    .err_range    (err_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: sample at negedge against the scoreboard, return #1 after posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (edge_q.size() > 0 && cyc == edge_q[0] && !pps_edge) begin
      chk("missing_edge", 32'(pps_edge), 32'(1));
      void'(edge_q.pop_front());
    end else if (pps_edge) begin
      if (edge_q.size() == 0) chk("unexpected_edge", 32'(pps_edge), 32'(0));
      else                    chk("edge_cycle", cyc, edge_q.pop_front());
    end
    if (exp_q.size() > 0 && cyc == exp_q[0].at && !interval_stb && !pps_out) begin
      chk("missing_stb", 32'(interval_stb), 32'(1));
      void'(exp_q.pop_front());
    end else if (interval_stb || pps_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_stb", 32'({interval_stb, pps_out}), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("stb_cycle", cyc, e.at);
        chk("interval_stb", 32'(interval_stb), 32'(1));
        chk("interval", interval, e.iv);
        chk("pps_out", 32'(pps_out), 32'(e.pps));
        chk("locked_at_stb", 32'(locked), 32'(e.lck));
        chk("err_range_at_stb", 32'(err_range), 32'(e.er));
        chk("err_missing_at_stb", 32'(err_missing), 32'(e.em));
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  // Pulse raised after edge c: accept cycle c+4, interval_stb cycle c+5.
  task automatic pulse(input int c, input int high, input bit has_edge, input bit has_stb,
                       input logic [31:0] iv, input logic p, input logic l,
                       input logic er, input logic em);
    goto(c);
    if (has_edge) edge_q.push_back(c + 4);
    if (has_stb) exp_q.push_back('{at: c + 5, iv: iv, pps: p, lck: l, er: er, em: em});
    pps_in = 1'b1;
    repeat (high) tick();
    pps_in = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pps_edge"}, 32'(pps_edge), 32'(0));
    chk({tag, "_pps_out"}, 32'(pps_out), 32'(0));
    chk({tag, "_interval"}, interval, 32'(0));
    chk({tag, "_interval_stb"}, 32'(interval_stb), 32'(0));
    chk({tag, "_locked"}, 32'(locked), 32'(0));
    chk({tag, "_err_missing"}, 32'(err_missing), 32'(0));
    chk({tag, "_err_range"}, 32'(err_range), 32'(0));
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    cyc         = 0;
    rst         = 1'b1;
    pps_in      = 1'b0;
    clear_flags = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Clean stream: lock after three good intervals.
    for (int i = 0; i < 5; i++)
      pulse(10 + 100 * i, 10, 1'b1, i > 0, 32'd100, 1'b1, i >= 3, 1'b0, 1'b0);
    goto(420);
    chk("s1_locked", 32'(locked), 32'(1));
    chk("s1_err_range", 32'(err_range), 32'(0));
    chk("s1_err_missing", 32'(err_missing), 32'(0));
    chk("s1_pending", edge_q.size() + exp_q.size(), 0);

    // Short glitch is ignored; the next edge still measures 100.
    pulse(460, 2, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(510, 10, 1'b1, 1'b1, 32'd100, 1'b1, 1'b1, 1'b0, 1'b0);
    goto(520);
    chk("s2_locked", 32'(locked), 32'(1));

    // Early edge breaks lock, then relock after three good intervals.
    pulse(607, 10, 1'b1, 1'b1, 32'd97, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse(707, 10, 1'b1, 1'b1, 32'd100, 1'b1, 1'b0, 1'b1, 1'b0);
    pulse(807, 10, 1'b1, 1'b1, 32'd100, 1'b1, 1'b0, 1'b1, 1'b0);
    pulse(907, 10, 1'b1, 1'b1, 32'd100, 1'b1, 1'b1, 1'b1, 1'b0);
    goto(950);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("s3_clear_range", 32'(err_range), 32'(0));
    chk("s3_locked", 32'(locked), 32'(1));

    // Stream stops: timeout one cycle after counter reaches 101.
    goto(1013);
    chk("s4_missing_before", 32'(err_missing), 32'(0));
    chk("s4_locked_before", 32'(locked), 32'(1));
    goto(1014);
    chk("s4_missing_after", 32'(err_missing), 32'(1));
    chk("s4_locked_after", 32'(locked), 32'(0));
    goto(1050);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("s4_clear_missing", 32'(err_missing), 32'(0));
    pulse(1100, 10, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Edge in the last cycle of the window is good, not a timeout.
    pulse(1202, 10, 1'b1, 1'b1, 32'd102, 1'b1, 1'b0, 1'b0, 1'b0);
    goto(1210);
    chk("s5_no_missing", 32'(err_missing), 32'(0));

    // clear_flags coincident with a range error: the set wins.
    goto(1292);
    edge_q.push_back(1296);
    exp_q.push_back('{at: 1297, iv: 32'd90, pps: 1'b0, lck: 1'b0, er: 1'b1, em: 1'b0});
    pps_in = 1'b1;
    goto(1296);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    goto(1302);
    pps_in = 1'b0;
    goto(1305);
    chk("s5_range_set_wins", 32'(err_range), 32'(1));

    // Asynchronous reset mid-period clears everything without a clock edge.
    goto(1336);
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    tick();
    tick();
    rst = 1'b0;
    pulse(1400, 10, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1500, 10, 1'b1, 1'b1, 32'd100, 1'b1, 1'b0, 1'b0, 1'b0);
    goto(1520);
    chk("final_pending", edge_q.size() + exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
